// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types, result encoding and sizing helpers for the sequential
// magnitude comparator.
package cmp_pkg;

  // Controller states: waiting for a request, or scanning digits.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result vector layout is {gt, eq, lt}; exactly one bit set after a compare.
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Number of DIGIT_W-bit digits in a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  // Width of the digit index: ceil(log2(nd)), never narrower than one bit.
  function automatic int idx_width(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Unsigned compare of two DIGIT_W-bit digits; the generalised form of the
// old 2-bit greater-than block. Both outputs low means the digits are equal.
module digit_compare
  import cmp_pkg::*;
#(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] da,
  input  logic [DIGIT_W-1:0] db,
  output logic               dgt,
  output logic               dlt
);

  assign dgt = (da > db);
  assign dlt = (da < db);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Operands are scanned MSB-first, one digit
// per clock, stopping at the first differing digit. Signed compares are turned
// into unsigned ones by flipping the sign bit of both operands at capture.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int               NUM_DIGITS = num_digits(WIDTH, DIGIT_W);
  localparam int               IDX_W      = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [WIDTH-1:0] SIGN_MASK  = WIDTH'(1) << (WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   a_d, b_d;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic [2:0]         res_q;
  logic [DIGIT_W-1:0] dig_a, dig_b;
  logic               dgt, dlt;

  // Offset-binary conversion: flipping the MSB maps two's-complement order
  // onto unsigned order, so the scan itself never needs to know the mode.
  assign a_d = a ^ (signed_mode ? SIGN_MASK : '0);
  assign b_d = b ^ (signed_mode ? SIGN_MASK : '0);

  // Digit currently under examination; idx_q never exceeds NUM_DIGITS-1.
  assign dig_a = a_q[int'(idx_q) * DIGIT_W +: DIGIT_W];
  assign dig_b = b_q[int'(idx_q) * DIGIT_W +: DIGIT_W];

  digit_compare #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_compare (
    .da  (dig_a),
    .db  (dig_b),
    .dgt (dgt),
    .dlt (dlt)
  );

  // Controller, operand capture, digit index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (dgt || dlt) begin
            // First differing digit decides the whole compare.
            res_q   <= dgt ? RES_GT : RES_LT;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            // Every digit matched down to the bottom one.
            res_q   <= RES_EQ;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = res_q[2];
  assign eq   = res_q[1];
  assign lt   = res_q[0];

endmodule
